// File: rtl/addr_counter.sv
// addr_counter: split high/low address register (PC and D/T address temporaries).
// It supports per-half loads, full-width inc/dec, and low-half offset addition.
// When an addition crosses a page, the high-half correction is deferred: it is
// applied on a later fix_en, or automatically on the next edge when AUTO_FIX=1.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   ld_h/d_h, ld_l/d_l    per-half load
//   inc, dec              full-width +1 / -1
//   add_en/add_off        low-half add; add_signed selects a two's complement offset
//   fix_en                apply the owed high-half fixup (AUTO_FIX=0 only)
//   out_l, out_h, addr    registered address, as halves and whole
//   fix_pending, fix_dir  a fixup is owed, and its direction (1 = +1)
//   page_cross            one-cycle pulse on entry to the pending state
module addr_counter #(
    parameter int                    LO_W     = 8,
    parameter int                    HI_W     = 8,
    parameter int                    AUTO_FIX = 0,
    parameter logic [HI_W+LO_W-1:0]  RST_VAL  = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ld_h,
    input  logic                 ld_l,
    input  logic [HI_W-1:0]      d_h,
    input  logic [LO_W-1:0]      d_l,
    input  logic                 inc,
    input  logic                 dec,
    input  logic                 add_en,
    input  logic [LO_W-1:0]      add_off,
    input  logic                 add_signed,
    input  logic                 fix_en,
    output logic [LO_W-1:0]      out_l,
    output logic [HI_W-1:0]      out_h,
    output logic [HI_W+LO_W-1:0] addr,
    output logic                 fix_pending,
    output logic                 fix_dir,
    output logic                 page_cross
);

    localparam int AW = HI_W + LO_W;
    localparam logic [HI_W-1:0] HI_ONE = HI_W'(1);
    localparam logic [AW-1:0]   AW_ONE = AW'(1);

    typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

    state_t          state, state_nx;
    logic [HI_W-1:0] hi_q, hi_nx;
    logic [LO_W-1:0] lo_q, lo_nx;
    logic            dir_q, dir_nx;
    logic            pc_q, pc_nx;

    logic [AW-1:0]   full_inc, full_dec;
    logic [LO_W:0]   sum;
    logic            neg, cross_up, cross_dn, add_cross;

    assign full_inc = {hi_q, lo_q} + AW_ONE;
    assign full_dec = {hi_q, lo_q} - AW_ONE;
    assign sum      = {1'b0, lo_q} + {1'b0, add_off};
    // A negative offset always produces a carry unless the result fell below
    // the page start, so for negative offsets "no carry" means a borrow.
    assign neg       = add_signed & add_off[LO_W-1];
    assign cross_up  = sum[LO_W] & ~neg;
    assign cross_dn  = ~sum[LO_W] & neg;
    assign add_cross = cross_up | cross_dn;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            {hi_q, lo_q} <= RST_VAL;
            dir_q <= 1'b0;
            pc_q  <= 1'b0;
        end else begin
            state <= state_nx;
            hi_q  <= hi_nx;
            lo_q  <= lo_nx;
            dir_q <= dir_nx;
            pc_q  <= pc_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (!inc && !dec && add_en && add_cross) state_nx = PEND;
            PEND: if ((AUTO_FIX != 0) || fix_en || ld_h || ld_l) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        hi_nx  = hi_q;
        lo_nx  = lo_q;
        dir_nx = dir_q;
        pc_nx  = 1'b0;
        if (state == IDLE) begin
            if (inc) begin
                {hi_nx, lo_nx} = full_inc;
            end else if (dec) begin
                {hi_nx, lo_nx} = full_dec;
            end else if (add_en) begin
                lo_nx = sum[LO_W-1:0];
                if (add_cross) begin
                    dir_nx = cross_up;
                    pc_nx  = 1'b1;
                end
            end else begin
                if (ld_h) hi_nx = d_h;
                if (ld_l) lo_nx = d_l;
            end
        end else begin
            if ((AUTO_FIX != 0) || fix_en) begin
                hi_nx = dir_q ? hi_q + HI_ONE : hi_q - HI_ONE;
            end else begin
                // A load while pending discards the owed fixup.
                if (ld_h) hi_nx = d_h;
                if (ld_l) lo_nx = d_l;
            end
        end
    end

    assign out_l       = lo_q;
    assign out_h       = hi_q;
    assign addr        = {hi_q, lo_q};
    assign fix_pending = (state == PEND);
    assign fix_dir     = dir_q;
    assign page_cross  = pc_q;

endmodule

// File: tb/tb_addr_counter.sv
module tb_addr_counter;

    typedef struct {
        bit       rst, ld_h, ld_l, inc, dec, add_en, add_signed, fix_en;
        bit [7:0] d_h, d_l, add_off;
    } stim_t;

    typedef struct {
        int a;
        bit pend, dir, pc;
    } mdl_t;

    typedef struct {
        mdl_t m0, m1;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0, ld_h = 1'b0, ld_l = 1'b0, inc = 1'b0, dec = 1'b0;
    logic        add_en = 1'b0, add_signed = 1'b0, fix_en = 1'b0;
    logic [7:0]  d_h = '0, d_l = '0, add_off = '0;

    logic [7:0]  out_l0, out_h0, out_l1, out_h1;
    logic [15:0] addr0, addr1;
    logic        fp0, fd0, pc0, fp1, fd1, pc1;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t q[$];
    mdl_t m0, m1;

    always #5 clk = ~clk;

    addr_counter #(.LO_W(8), .HI_W(8), .AUTO_FIX(0), .RST_VAL(16'hFFFC)) u0 (
        .clk(clk), .rst(rst), .ld_h(ld_h), .ld_l(ld_l), .d_h(d_h), .d_l(d_l),
        .inc(inc), .dec(dec), .add_en(add_en), .add_off(add_off),
        .add_signed(add_signed), .fix_en(fix_en), .out_l(out_l0), .out_h(out_h0),
        .addr(addr0), .fix_pending(fp0), .fix_dir(fd0), .page_cross(pc0));

    addr_counter #(.LO_W(8), .HI_W(8), .AUTO_FIX(1), .RST_VAL(16'h0000)) u1 (
        .clk(clk), .rst(rst), .ld_h(ld_h), .ld_l(ld_l), .d_h(d_h), .d_l(d_l),
        .inc(inc), .dec(dec), .add_en(add_en), .add_off(add_off),
        .add_signed(add_signed), .fix_en(fix_en), .out_l(out_l1), .out_h(out_h1),
        .addr(addr1), .fix_pending(fp1), .fix_dir(fd1), .page_cross(pc1));

    // Reference model: address as a plain integer; page crossing is judged by
    // whether the offset target leaves the 0..255 range of the current page.
    function automatic mdl_t step(mdl_t m, stim_t s, bit af, int rv);
        mdl_t n;
        int hi, lo, so, tgt;
        n  = m;
        hi = m.a / 256;
        lo = m.a % 256;
        n.pc = 1'b0;
        if (s.rst) begin
            n.a = rv; n.pend = 1'b0; n.dir = 1'b0;
        end else if (!m.pend) begin
            if (s.inc) n.a = (m.a + 1) % 65536;
            else if (s.dec) n.a = (m.a + 65535) % 65536;
            else if (s.add_en) begin
                so  = (s.add_signed && s.add_off >= 128) ? int'(s.add_off) - 256 : int'(s.add_off);
                tgt = lo + so;
                n.a = hi * 256 + ((tgt + 256) % 256);
                if (tgt > 255 || tgt < 0) begin
                    n.pend = 1'b1; n.dir = (tgt > 255); n.pc = 1'b1;
                end
            end else begin
                if (s.ld_h) hi = int'(s.d_h);
                if (s.ld_l) lo = int'(s.d_l);
                n.a = hi * 256 + lo;
            end
        end else if (af || s.fix_en) begin
            hi = m.dir ? (hi + 1) % 256 : (hi + 255) % 256;
            n.a = hi * 256 + lo;
            n.pend = 1'b0;
        end else if (s.ld_h || s.ld_l) begin
            if (s.ld_h) hi = int'(s.d_h);
            if (s.ld_l) lo = int'(s.d_l);
            n.a = hi * 256 + lo;
            n.pend = 1'b0;
        end
        return n;
    endfunction

    task automatic chk(string nm, int act, int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Drive one cycle of stimulus and record what the DUTs must show afterwards.
    task automatic drive(stim_t s);
        exp_t e;
        @(negedge clk);
        rst = s.rst; ld_h = s.ld_h; ld_l = s.ld_l; inc = s.inc; dec = s.dec;
        add_en = s.add_en; add_signed = s.add_signed; fix_en = s.fix_en;
        d_h = s.d_h; d_l = s.d_l; add_off = s.add_off;
        m0 = step(m0, s, 1'b0, 'hFFFC);
        m1 = step(m1, s, 1'b1, 0);
        e.m0 = m0; e.m1 = m1;
        q.push_back(e);
    endtask

    function automatic stim_t nop();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    task automatic t_nop();  drive(nop()); endtask
    task automatic t_rst();  stim_t s; s = nop(); s.rst = 1; drive(s); endtask
    task automatic t_inc();  stim_t s; s = nop(); s.inc = 1; drive(s); endtask
    task automatic t_dec();  stim_t s; s = nop(); s.dec = 1; drive(s); endtask
    task automatic t_fix();  stim_t s; s = nop(); s.fix_en = 1; drive(s); endtask
    task automatic t_ld(bit [7:0] h, bit [7:0] l, bit lh, bit ll);
        stim_t s; s = nop(); s.ld_h = lh; s.ld_l = ll; s.d_h = h; s.d_l = l; drive(s);
    endtask
    task automatic t_add(bit [7:0] off, bit sg);
        stim_t s; s = nop(); s.add_en = 1; s.add_off = off; s.add_signed = sg; drive(s);
    endtask

    // Monitor: registered outputs are valid every cycle, so compare once per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("u0.addr",  int'(addr0), e.m0.a);
                chk("u0.halves", int'({out_h0, out_l0}), e.m0.a);
                chk("u0.fix_pending", int'(fp0), int'(e.m0.pend));
                chk("u0.fix_dir", int'(fd0), int'(e.m0.dir));
                chk("u0.page_cross", int'(pc0), int'(e.m0.pc));
                chk("u1.addr",  int'(addr1), e.m1.a);
                chk("u1.halves", int'({out_h1, out_l1}), e.m1.a);
                chk("u1.fix_pending", int'(fp1), int'(e.m1.pend));
                chk("u1.fix_dir", int'(fd1), int'(e.m1.dir));
                chk("u1.page_cross", int'(pc1), int'(e.m1.pc));
            end
        end
    end

    initial begin
        stim_t s;
        int wait_cyc;
        m0 = '{a: 0, pend: 0, dir: 0, pc: 0};
        m1 = m0;

        // Reset, then wrap FFFC up through 0000
        t_rst();
        repeat (4) t_inc();
        // Combined load, inc across page, dec back
        t_ld(8'h12, 8'hFF, 1, 1); t_inc(); t_dec();
        // Unsigned add crossing up; inc while pending is ignored; fix
        t_ld(8'h12, 8'hF0, 1, 1); t_add(8'h20, 0); t_inc(); t_fix(); t_nop();
        // Signed add crossing down, fix; signed add without crossing
        t_ld(8'h12, 8'h05, 1, 1); t_add(8'hF0, 1); t_fix();
        t_ld(8'h12, 8'h05, 1, 1); t_add(8'h10, 1); t_fix();
        // Load low half while pending drops the fixup
        t_ld(8'h12, 8'hF0, 1, 1); t_add(8'h20, 0); t_ld(8'h00, 8'h44, 0, 1); t_nop();
        // Reset while pending
        t_ld(8'h12, 8'hF0, 1, 1); t_add(8'h20, 0); t_rst();
        // Page-crossing adds near the top/bottom of the address space
        t_ld(8'h00, 8'hFF, 1, 1); t_add(8'h01, 0); t_nop();
        t_ld(8'hFF, 8'hFF, 1, 1); t_add(8'h01, 0); t_nop(); t_fix(); t_nop();
        t_ld(8'h00, 8'h00, 1, 1); t_add(8'hFF, 1); t_nop(); t_fix();
        t_ld(8'h00, 8'h00, 1, 1); t_dec();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            s = nop();
            s.rst        = ($urandom_range(0, 99) < 2);
            s.ld_h       = ($urandom_range(0, 5) == 0);
            s.ld_l       = ($urandom_range(0, 5) == 0);
            s.inc        = ($urandom_range(0, 7) == 0);
            s.dec        = ($urandom_range(0, 7) == 0);
            s.add_en     = ($urandom_range(0, 2) == 0);
            s.add_signed = $urandom_range(0, 1) == 1;
            s.fix_en     = ($urandom_range(0, 3) == 0);
            s.d_h        = 8'($urandom);
            s.d_l        = 8'($urandom);
            s.add_off    = 8'($urandom);
            drive(s);
        end
        t_nop();

        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        #2;
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d entries left expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
